// File: rtl/quad_encoder_gen_pkg.sv
// Shared types and phase tables for the quadrature encoder generator.
// ENC_BOUNCE_EN raises the minimum step period so each bounced edge fits.
package quad_encoder_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   // Phase is {a, b}.
   typedef logic [1:0] phase_t;

   // Next phase indexed by the current phase: entry i sits at bits [2i+1:2i].
   localparam logic [7:0] CW_NEXT  = {2'b01, 2'b11, 2'b00, 2'b10};
   localparam logic [7:0] CCW_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};

`ifdef ENC_BOUNCE_EN
   localparam int MIN_PERIOD = 3;
`else
   localparam int MIN_PERIOD = 1;
`endif

endpackage

// File: rtl/quad_phase_step.sv
// Next-phase lookup: current (a,b) phase and direction to the following phase.
module quad_phase_step
   import quad_encoder_gen_pkg::*;
(
   input  phase_t phase,
   input  logic   dir,
   output phase_t next_phase
);

   logic [2:0] idx;

   assign idx        = {phase, 1'b0};
   assign next_phase = dir ? CW_NEXT[idx +: 2] : CCW_NEXT[idx +: 2];

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder pattern generator: emits N A/B transitions at a fixed period.
// Define ENC_BOUNCE_EN to emit every edge as new/old/new contact bounce.
module quad_encoder_gen
   import quad_encoder_gen_pkg::*;
#(
   parameter int STEP_W = 16,
   parameter int DIV_W  = 16,
   parameter int POS_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0]  cmd_period,
   input  logic              abort,
   output logic              enc_a,
   output logic              enc_b,
   output logic              busy,
   output logic              done,
   output logic [POS_W-1:0]  position,
   output state_t            state_dbg
);

   // Handshake: a command transfers on a rising edge where cmd_valid and
   // cmd_ready are both high; cmd_ready is high only in IDLE, so commands
   // offered while busy are simply not taken.

   state_t             state_q, state_d;
   phase_t             phase_q, nxt_phase;
   logic               dir_q, dir_sel;
   logic [DIV_W-1:0]   per_q, per_in, per_sel, cnt_q, cnt_load;
   logic [STEP_W-1:0]  rem_q, rem_after;
   logic               accept, emit, finish, zero_acc;

   assign accept    = cmd_valid && cmd_ready;
   assign per_in    = (cmd_period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : cmd_period;
   assign per_sel   = (state_q == ST_IDLE) ? per_in : per_q;
   assign dir_sel   = (state_q == ST_IDLE) ? cmd_dir : dir_q;
   assign rem_after = (state_q == ST_IDLE) ? cmd_steps - STEP_W'(1) : rem_q - STEP_W'(1);
   // WAIT burns per-2 cycles, STEP takes one more, the emitting edge closes the period.
   assign cnt_load  = (per_sel > DIV_W'(1)) ? per_sel - DIV_W'(2) : '0;

   quad_phase_step u_phase_step (
      .phase      (phase_q),
      .dir        (dir_sel),
      .next_phase (nxt_phase)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      finish   = 1'b0;
      zero_acc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_steps == '0) begin
                  zero_acc = 1'b1;
               end else begin
                  emit    = 1'b1;
                  state_d = (rem_after != '0 && per_sel == DIV_W'(1)) ? ST_STEP : ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // rem_q == 0 here means the final transition is already out.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (rem_q == '0) begin
               state_d = ST_IDLE;
               finish  = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               emit    = 1'b1;
               state_d = (rem_after != '0 && per_sel == DIV_W'(1)) ? ST_STEP : ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      state_dbg = state_q;
      if (state_q == ST_IDLE) cmd_ready = 1'b1;
      else                    busy      = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q  <= 2'b00;
         position <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         per_q    <= '0;
         done     <= 1'b0;
      end else begin
         done <= finish | zero_acc;
         if (emit) begin
            phase_q  <= nxt_phase;
            position <= dir_sel ? position + POS_W'(1) : position - POS_W'(1);
            rem_q    <= rem_after;
            cnt_q    <= cnt_load;
         end else if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
         end
         if (accept) begin
            dir_q <= cmd_dir;
            per_q <= per_in;
         end
      end
   end

`ifdef ENC_BOUNCE_EN
   phase_t     enc_q, old_q;
   logic [1:0] bnc_q;

   // The bounce runs to completion on its own, even if the command ends or aborts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enc_q <= 2'b00;
         old_q <= 2'b00;
         bnc_q <= 2'd0;
      end else if (emit) begin
         enc_q <= nxt_phase;
         old_q <= phase_q;
         bnc_q <= 2'd2;
      end else if (bnc_q == 2'd2) begin
         enc_q <= old_q;
         bnc_q <= 2'd1;
      end else if (bnc_q == 2'd1) begin
         enc_q <= phase_q;
         bnc_q <= 2'd0;
      end
   end

   assign enc_a = enc_q[1];
   assign enc_b = enc_q[0];
`else
   assign enc_a = phase_q[1];
   assign enc_b = phase_q[0];
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen; outputs are sampled on the falling edge.
// Build with ENC_BOUNCE_EN defined to exercise the bounced-edge variant.
module tb_quad_encoder_gen;
   import quad_encoder_gen_pkg::*;

   localparam int STEP_W = 16;
   localparam int DIV_W  = 16;
   localparam int POS_W  = 16;

   logic              clk        = 1'b0;
   logic              reset_n    = 1'b0;
   logic              cmd_valid  = 1'b0;
   logic              cmd_dir    = 1'b0;
   logic [STEP_W-1:0] cmd_steps  = '0;
   logic [DIV_W-1:0]  cmd_period = '0;
   logic              abort      = 1'b0;
   logic              cmd_ready, enc_a, enc_b, busy, done;
   logic [POS_W-1:0]  position;
   state_t            state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   quad_encoder_gen #(.STEP_W(STEP_W), .DIV_W(DIV_W), .POS_W(POS_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .cmd_period (cmd_period),
      .abort      (abort),
      .enc_a      (enc_a),
      .enc_b      (enc_b),
      .busy       (busy),
      .done       (done),
      .position   (position),
      .state_dbg  (state_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      reset_n   = 1'b0;
      repeat (2) cyc();
      chk("rst_ab", {enc_a, enc_b}, 2'b00);
      chk("rst_pos", position, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      reset_n = 1'b1;
      cyc();
      chk("rst_ready", cmd_ready, 1'b1);
   endtask

   task automatic send(input logic dir, input logic [STEP_W-1:0] steps, input logic [DIV_W-1:0] per);
      cmd_valid  = 1'b1;
      cmd_dir    = dir;
      cmd_steps  = steps;
      cmd_period = per;
   endtask

   initial begin
      do_reset();

`ifdef ENC_BOUNCE_EN
      // CW, 1 step, period 8: enc_a goes 1,0,1 then holds.
      send(1'b1, 16'd1, 16'd8);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         if (k == 1) cmd_valid = 1'b0;
         chk("bnc_a", enc_a, (k == 2) ? 1'b0 : 1'b1);
         chk("bnc_b", enc_b, 1'b0);
         chk("bnc_pos", position, 16'h0001);
         chk("bnc_done", done, k == 2);
      end
`else
      // CW, 4 steps, period 5 from phase 00.
      send(1'b1, 16'd4, 16'd5);
      for (int k = 1; k <= 17; k++) begin
         logic [1:0] exp_ab;
         cyc();
         if (k == 1) cmd_valid = 1'b0;
         exp_ab = (k < 6) ? 2'b10 : (k < 11) ? 2'b11 : (k < 16) ? 2'b01 : 2'b00;
         chk("t1_ab", {enc_a, enc_b}, exp_ab);
         chk("t1_busy", busy, k < 17);
         chk("t1_done", done, k == 17);
         chk("t1_ready", cmd_ready, k == 17);
         if (k == 6) chk("t1_pos_mid", position, 16'h0002);
      end
      chk("t1_pos", position, 16'h0004);

      // CCW, 3 steps, period 0 from a fresh reset.
      do_reset();
      send(1'b0, 16'd3, 16'd0);
      for (int k = 1; k <= 4; k++) begin
         logic [1:0] exp_ab;
         cyc();
         if (k == 1) cmd_valid = 1'b0;
         exp_ab = (k == 1) ? 2'b01 : (k == 2) ? 2'b11 : 2'b10;
         chk("t2_ab", {enc_a, enc_b}, exp_ab);
         chk("t2_busy", busy, k < 4);
         chk("t2_done", done, k == 4);
         if (k == 1) chk("t2_pos_first", position, 16'hFFFF);
      end
      chk("t2_pos", position, 16'hFFFD);

      // Zero-step command: done next cycle, never busy, outputs untouched.
      send(1'b1, 16'd0, 16'd7);
      for (int k = 1; k <= 2; k++) begin
         cyc();
         if (k == 1) cmd_valid = 1'b0;
         chk("t3_done", done, k == 1);
         chk("t3_busy", busy, 1'b0);
         chk("t3_ready", cmd_ready, 1'b1);
         chk("t3_ab", {enc_a, enc_b}, 2'b10);
         chk("t3_pos", position, 16'hFFFD);
      end

      // CW, 10 steps, period 4, aborted 2 cycles after the second transition.
      send(1'b1, 16'd10, 16'd4);
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (k == 1) cmd_valid = 1'b0;
         chk("t4_ab", {enc_a, enc_b}, (k < 5) ? 2'b11 : 2'b01);
         chk("t4_pos", position, (k < 5) ? 16'hFFFE : 16'hFFFF);
         chk("t4_busy", busy, k <= 7);
         chk("t4_done", done, 1'b0);
         if (k == 7) abort = 1'b1;
         if (k == 8) abort = 1'b0;
      end

      // Abort in IDLE is ignored; the new command continues from phase 01.
      send(1'b1, 16'd1, 16'd1);
      abort = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      chk("t4b_ab", {enc_a, enc_b}, 2'b00);
      chk("t4b_pos", position, 16'h0000);
      chk("t4b_busy", busy, 1'b1);
      cyc();
      chk("t4b_done", done, 1'b1);
      chk("t4b_idle", busy, 1'b0);

      // Walk position up to 0x7FFF with back-to-back CW transitions.
      send(1'b1, 16'h7FFF, 16'd0);
      cyc();
      cmd_valid = 1'b0;
      repeat (32767) cyc();
      chk("t5_done", done, 1'b1);
      chk("t5_pos", position, 16'h7FFF);
      chk("t5_ab", {enc_a, enc_b}, 2'b01);

      // cmd_valid held through the whole command: only one acceptance.
      send(1'b1, 16'd2, 16'd3);
      for (int k = 1; k <= 6; k++) begin
         cyc();
         chk("t6_ab", {enc_a, enc_b}, (k < 4) ? 2'b00 : 2'b10);
         chk("t6_pos", position, (k < 4) ? 16'h8000 : 16'h8001);
         chk("t6_busy", busy, k < 5);
         chk("t6_done", done, k == 5);
         if (k == 5) cmd_valid = 1'b0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
